lsu_mem_sequencer: RTL and testbench
====================================

# lsu_mem_sequencer

Serializes one warp's per-lane memory accesses onto the single-port data memory interface. Sits directly downstream of the address generation unit inside the LSU: it captures the eight lane addresses, the thread mask and, for stores, the eight lane data words. It then issues one memory request per active lane in ascending lane order, gathers load responses into a per-lane result register, and pulses `done` when the warp's access is complete.

## Interface
Parameters:
- DATA_WIDTH, 16, width of a lane data word and of memory data
- ADDR_WIDTH, 8, width of a memory address
- NUM_LANES, 8, lanes (threads) per warp; mask width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request to begin a warp access; sampled only in IDLE
- is_store  input  1  1 = store, 0 = load; captured with start
- thread_mask  input  NUM_LANES  active lanes; captured with start
- addr  input  ADDR_WIDTH x NUM_LANES  per-lane addresses from the address generation unit; captured with start
- store_data  input  DATA_WIDTH x NUM_LANES  per-lane store words; captured with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- load_data  output  DATA_WIDTH x NUM_LANES  registered per-lane load results
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_write  output  1  1 = write request
- mem_req_addr  output  ADDR_WIDTH  request address
- mem_req_wdata  output  DATA_WIDTH  write data
- mem_resp_valid  input  1  read data valid, one pulse per accepted read
- mem_resp_data  input  DATA_WIDTH  read data

## Operation
- States: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - On start, capture is_store, thread_mask into `pending`, addr and store_data.
  - If thread_mask != 0, go to ISSUE; otherwise go to DONE.
- ISSUE:
  - `lane` is the lowest set bit of `pending`.
  - mem_req_valid = 1, mem_req_addr = captured addr[lane], mem_req_write = is_store, mem_req_wdata = captured store_data[lane].
  - On handshake (valid & ready), clear pending[lane].
  - Store: if pending is now 0, go to DONE; otherwise stay in ISSUE.
  - Load: record `lane` in `resp_lane` and go to WAIT_RESP.
- WAIT_RESP:
  - mem_req_valid = 0.
  - On mem_resp_valid, load_data[resp_lane] <= mem_resp_data.
  - Then go to ISSUE if pending != 0, otherwise to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- load_data entries of inactive lanes, and all entries during stores, hold their previous values.
- start while busy is ignored. Captured inputs are not re-sampled until the next IDLE start.
- mem_resp_valid outside WAIT_RESP is ignored.
- Request outputs are functions of state and registers only, never of mem_req_ready.
- While mem_req_ready is low, request fields are held stable.

## Timing
- Reset values:
  - state = IDLE; busy = 0, done = 0, mem_req_valid = 0, mem_req_write = 0.
  - mem_req_addr = 0, mem_req_wdata = 0, pending = 0.
  - All load_data entries = 0.
- Reset mid-operation aborts immediately to IDLE, with the reset values above, on the next edge. No done pulse is produced.
- Start sampled at edge E: first request valid in cycle E+1.
- Stores with mem_req_ready held high: one lane per cycle, back-to-back. For N active lanes, done is asserted in cycle E+1+N.
- Loads: at least 2 cycles per lane (request, then response wait). Response latency is unbounded; the FSM waits indefinitely.
- Zero mask: done asserted in cycle E+1, and no memory request is issued.
- busy falls in the cycle after done; a new start is accepted in that cycle.

## Structure
- Shared package `lsu_pkg`: state enum (IDLE, ISSUE, WAIT_RESP, DONE) and the NUM_LANES/DATA_WIDTH/ADDR_WIDTH defaults, shared with the address generation unit.
- Sub-module `lsu_lane_picker`: combinational lowest-set-bit priority encoder over `pending`. Outputs a lane index of $clog2(NUM_LANES) bits and an `any` flag.

## Test plan
- Store, mask 8'hFF, addr[i] = 8'h10+i, store_data[i] = 16'hA000+i, ready always high -> eight writes in cycles 1–8 in lane order 0..7; done in cycle 9.
- Load, mask 8'b1010_0100, memory returns 16'h0100+addr, addr[i] = 8'h20+i -> requests to 8'h22, 8'h25, 8'h27 only.
  - load_data[2] = 16'h0122, load_data[5] = 16'h0125, load_data[7] = 16'h0127.
  - All other entries remain 0.
- Backpressure: store, mask 8'h03, mem_req_ready low for 3 cycles -> mem_req_addr and mem_req_wdata stable for lane 0 throughout the stall; lane 1 issued only after the lane 0 handshake.
- Zero mask, start -> done in cycle 1, mem_req_valid never high.
- Load with response delayed 5 cycles, start pulsed again while busy, reset asserted in WAIT_RESP -> second start ignored.
  - After reset: state IDLE, mem_req_valid = 0, load_data all 0, no done pulse.
  - A late mem_resp_valid after reset does not change load_data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: sequencer state encoding and default warp geometry,
// common to the address generation unit and the memory sequencer.
package lsu_pkg;

    localparam int LSU_NUM_LANES  = 8;
    localparam int LSU_DATA_WIDTH = 16;
    localparam int LSU_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_picker.sv
// Lowest-set-bit priority encoder over the pending-lane mask; lane 0 has the
// highest priority so accesses go out in ascending lane order.
module lsu_lane_picker
    import lsu_pkg::*;
#(
    parameter int NUM_LANES = LSU_NUM_LANES,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] pending,
    output logic [LANE_W-1:0]    lane,
    output logic                 any
);

    // Scan downwards so the last match, the lowest set bit, wins.
    always_comb begin
        lane = '0;
        any  = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lane = LANE_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Serializes one warp's per-lane loads/stores onto the single-port data memory
// and gathers load responses into a per-lane result register.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start; warp inputs captured on start
//   ISSUE     | presenting the request of the lowest pending lane
//   WAIT_RESP | load issued, waiting (unbounded) for its response
//   DONE      | one-cycle completion pulse, then back to IDLE
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int NUM_LANES  = LSU_NUM_LANES
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 is_store,
    input  logic [NUM_LANES-1:0]                 thread_mask,
    input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] store_data,
    output logic                                 busy,
    output logic                                 done,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] load_data,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic                                 mem_req_write,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    output logic [DATA_WIDTH-1:0]                mem_req_wdata,
    input  logic                                 mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                mem_resp_data
);

    localparam int LANE_W = $clog2(NUM_LANES);

    lsu_state_e                           state_q, state_d;
    logic                                 is_store_q;
    logic [NUM_LANES-1:0]                 pending_q;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata_q;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] load_data_q;
    logic [LANE_W-1:0]                    resp_lane_q;

    logic [LANE_W-1:0]                    lane;
    logic                                 any_pending;
    logic [NUM_LANES-1:0]                 lane_onehot;
    logic [NUM_LANES-1:0]                 pending_after;
    logic                                 capture;
    logic                                 req_fire;
    logic                                 resp_take;

    lsu_lane_picker #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_lane_picker (
        .pending (pending_q),
        .lane    (lane),
        .any     (any_pending)
    );

    assign lane_onehot   = NUM_LANES'(1) << lane;
    assign pending_after = pending_q & ~lane_onehot;
    assign capture       = (state_q == IDLE) && start;
    assign req_fire      = (state_q == ISSUE) && mem_req_ready;
    assign resp_take     = (state_q == WAIT_RESP) && mem_resp_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (thread_mask != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    if (is_store_q) begin
                        state_d = (pending_after == '0) ? DONE : ISSUE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    state_d = any_pending ? ISSUE : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields depend only on registered state, so they stay put while
    // the memory stalls with mem_req_ready low.
    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (state_q == ISSUE) begin
            mem_req_valid = 1'b1;
            mem_req_write = is_store_q;
            mem_req_addr  = addr_q[lane];
            mem_req_wdata = wdata_q[lane];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            pending_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_lane_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                is_store_q <= is_store;
                pending_q  <= thread_mask;
                addr_q     <= addr;
                wdata_q    <= store_data;
            end
            if (req_fire) begin
                pending_q   <= pending_after;
                resp_lane_q <= lane;
            end
            if (resp_take) begin
                load_data_q[resp_lane_q] <= mem_resp_data;
            end
        end
    end

    assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed scenarios plus randomized warps checked
// against a lane-queue / memory-response reference model.
module tb_lsu_mem_sequencer;

    logic              clk;
    logic              reset;
    logic              start;
    logic              is_store;
    logic [7:0]        thread_mask;
    logic [7:0][7:0]   addr;
    logic [7:0][15:0]  store_data;
    logic              busy;
    logic              done;
    logic [7:0][15:0]  load_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [7:0]        mem_req_addr;
    logic [15:0]       mem_req_wdata;
    logic              mem_resp_valid;
    logic [15:0]       mem_resp_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  t_addr  [8];
    logic [15:0] t_wdata [8];
    logic [15:0] exp_ld  [8];

    lsu_mem_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .is_store       (is_store),
        .thread_mask    (thread_mask),
        .addr           (addr),
        .store_data     (store_data),
        .busy           (busy),
        .done           (done),
        .load_data      (load_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_load_data(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_ld%0d", tag, i), 32'(load_data[i]), 32'(exp_ld[i]));
        end
    endtask

    // Runs one warp starting in the current (IDLE) cycle. Cycle 1 is the cycle
    // after the start edge. Returns at the negedge of the IDLE cycle after done.
    task automatic run_warp(input bit st, input logic [7:0] mask, input int ready_pct,
                            input int stall_first, input int max_delay,
                            input bit rand_resp, output int done_cyc);
        int          q[$];
        int          out_lane;
        int          cnt;
        int          l;
        bit          outst;
        bit          rdy;
        logic [15:0] rd;
        for (int i = 0; i < 8; i++) if (mask[i]) q.push_back(i);
        start       = 1'b1;
        is_store    = st;
        thread_mask = mask;
        for (int i = 0; i < 8; i++) begin
            addr[i]       = t_addr[i];
            store_data[i] = t_wdata[i];
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        thread_mask = 8'($urandom);
        is_store    = ~st;
        for (int i = 0; i < 8; i++) begin
            addr[i]       = 8'($urandom);
            store_data[i] = 16'($urandom);
        end
        outst    = 1'b0;
        out_lane = 0;
        cnt      = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            chk("busy_active", 32'(busy), 32'd1);
            if (done) begin
                done_cyc = cyc;
                chk("done_all_served", 32'(q.size() + int'(outst)), 32'd0);
                chk("valid_in_done", 32'(mem_req_valid), 32'd0);
                break;
            end
            chk("req_valid", 32'(mem_req_valid), 32'(q.size() != 0 && !outst));
            if (outst) begin
                if (cnt == 0) begin
                    rd = rand_resp ? 16'($urandom) : 16'h0100 + 16'(t_addr[out_lane]);
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rd;
                    exp_ld[out_lane] = rd;
                    outst = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_req_valid && q.size() != 0) begin
                chk("req_addr", 32'(mem_req_addr), 32'(t_addr[q[0]]));
                chk("req_write", 32'(mem_req_write), 32'(st));
                chk("req_wdata", 32'(mem_req_wdata), 32'(t_wdata[q[0]]));
                rdy = (cyc > stall_first) && ($urandom_range(99) < ready_pct);
                mem_req_ready = rdy;
                if ($urandom_range(3) == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = 16'($urandom);
                end
                if (rdy) begin
                    l = q.pop_front();
                    if (!st) begin
                        outst    = 1'b1;
                        out_lane = l;
                        cnt      = $urandom_range(max_delay, 0);
                    end
                end
            end
        end
        n_assert++;
        assert (done_cyc >= 0) else begin
            n_fail++;
            $error("FAIL warp_timeout: observed no done expected done within 400 cycles");
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("valid_idle", 32'(mem_req_valid), 32'd0);
        chk_load_data("warp");
    endtask

    initial begin
        int dc;
        reset          = 1'b1;
        start          = 1'b0;
        is_store       = 1'b0;
        thread_mask    = '0;
        addr           = '0;
        store_data     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        for (int i = 0; i < 8; i++) exp_ld[i] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_write", 32'(mem_req_write), 32'd0);
        chk("rst_addr", 32'(mem_req_addr), 32'd0);
        chk("rst_wdata", 32'(mem_req_wdata), 32'd0);
        chk_load_data("rst");
        reset = 1'b0;
        @(negedge clk);

        // Full-mask store, ready always high: back-to-back lanes, done in cycle 9.
        for (int i = 0; i < 8; i++) begin
            t_addr[i]  = 8'h10 + 8'(i);
            t_wdata[i] = 16'hA000 + 16'(i);
        end
        run_warp(1'b1, 8'hFF, 100, 0, 0, 1'b0, dc);
        chk("store_ff_done_cycle", 32'(dc), 32'd9);

        // Sparse load, memory returns 0x0100+addr with no extra delay.
        for (int i = 0; i < 8; i++) begin
            t_addr[i]  = 8'h20 + 8'(i);
            t_wdata[i] = 16'h5500 + 16'(i);
        end
        run_warp(1'b0, 8'b1010_0100, 100, 0, 0, 1'b0, dc);
        chk("load_a4_done_cycle", 32'(dc), 32'd7);
        chk("load_a4_ld2", 32'(load_data[2]), 32'h0122);
        chk("load_a4_ld5", 32'(load_data[5]), 32'h0125);
        chk("load_a4_ld7", 32'(load_data[7]), 32'h0127);
        chk("load_a4_ld0", 32'(load_data[0]), 32'h0);

        // Backpressure: ready low for three cycles on lane 0.
        for (int i = 0; i < 8; i++) begin
            t_addr[i]  = 8'h40 + 8'(i);
            t_wdata[i] = 16'hB000 + 16'(i);
        end
        run_warp(1'b1, 8'h03, 100, 3, 0, 1'b0, dc);
        chk("stall_done_cycle", 32'(dc), 32'd6);

        // Zero mask: done in cycle 1, no request.
        run_warp(1'b0, 8'h00, 100, 0, 0, 1'b0, dc);
        chk("zero_mask_done_cycle", 32'(dc), 32'd1);

        // Reset while waiting for a delayed load response.
        for (int i = 0; i < 8; i++) t_addr[i] = 8'h60 + 8'(i);
        start       = 1'b1;
        is_store    = 1'b0;
        thread_mask = 8'h01;
        for (int i = 0; i < 8; i++) addr[i] = t_addr[i];
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_req_valid", 32'(mem_req_valid), 32'd1);
        chk("abort_req_addr", 32'(mem_req_addr), 32'h60);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        start         = 1'b1;
        is_store      = 1'b1;
        thread_mask   = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        chk("abort_wait_valid", 32'(mem_req_valid), 32'd0);
        chk("abort_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("abort_restart_ignored", 32'(mem_req_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_ld[i] = 16'h0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_valid", 32'(mem_req_valid), 32'd0);
        chk("abort_addr", 32'(mem_req_addr), 32'd0);
        chk_load_data("abort");
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'hDEAD;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("late_resp_no_done", 32'(done), 32'd0);
            chk("late_resp_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        chk_load_data("late_resp");

        // Randomized warps: random mask, direction, backpressure and latency.
        for (int w = 0; w < 40; w++) begin
            for (int i = 0; i < 8; i++) begin
                t_addr[i]  = 8'($urandom);
                t_wdata[i] = 16'($urandom);
            end
            run_warp(1'($urandom), 8'($urandom), 70, 0, 4, 1'b1, dc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
